// File: rtl/multi_channel_xor_stream_cipher.sv
`timescale 1ns/1ps
`default_nettype none
// multi_channel_xor_stream_cipher: C bit-serial Galois-LFSR XOR cipher channels that share
// one serial config chain; the chain commits to every channel only after a full L-bit shift.
module multi_channel_xor_stream_cipher #(
  parameter int N = 32,
  parameter int C = 2,
  parameter logic [N-1:0] TAPS_DEFAULT = 'h48000000,
  parameter logic [N-1:0] SEED_DEFAULT = 'h00000055
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cfg_en,
  input  logic         cfg_i,
  output logic         cfg_o,
  output logic         cfg_done,
  input  logic [C-1:0] data_i,
  input  logic [C-1:0] valid_i,
  input  logic [C-1:0] resync,
  output logic [C-1:0] data_o,
  output logic [C-1:0] valid_o,
  output logic [C-1:0] locked
);
  localparam int L  = 2 * N * C;
  localparam int CW = $clog2(L + 1);
  localparam logic [L-1:0]  SHADOW_RST = {C{TAPS_DEFAULT, SEED_DEFAULT}};
  localparam logic [CW-1:0] CNT_LAST   = CW'(L - 1);

  logic [L-1:0]  shadow;
  logic [L-1:0]  shadow_nxt;
  logic [CW-1:0] cnt;
  logic          commit;

  // Commit samples the shadow as it will be after this edge's shift.
  assign shadow_nxt = {cfg_i, shadow[L-1:1]};
  assign commit     = cfg_en && (cnt == CNT_LAST);
  assign cfg_o      = cfg_en & shadow[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow   <= SHADOW_RST;
      cnt      <= '0;
      cfg_done <= 1'b0;
    end else begin
      cfg_done <= commit;
      if (cfg_en) begin
        shadow <= shadow_nxt;
        cnt    <= commit ? '0 : cnt + 1'b1;
      end else begin
        cnt <= '0;
      end
    end
  end

  for (genvar ch = 0; ch < C; ch++) begin : g_ch
    logic [N-1:0] state;
    logic [N-1:0] taps_a;
    logic [N-1:0] seed_a;
    logic         key;
    logic         accept;
    logic         dout;
    logic         vout;

    assign key         = state[0];
    assign locked[ch]  = (state == '0);
    assign accept      = valid_i[ch] & ~cfg_en & ~locked[ch];
    assign data_o[ch]  = dout;
    assign valid_o[ch] = vout;

    // Priority: commit > resync > step > hold; the output bit always uses the pre-update key.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state  <= SEED_DEFAULT;
        taps_a <= TAPS_DEFAULT;
        seed_a <= SEED_DEFAULT;
        dout   <= 1'b0;
        vout   <= 1'b0;
      end else begin
        vout <= accept;
        dout <= accept & (data_i[ch] ^ key);
        if (commit) begin
          taps_a <= shadow_nxt[2*N*ch+N +: N];
          seed_a <= shadow_nxt[2*N*ch +: N];
          state  <= shadow_nxt[2*N*ch +: N];
        end else if (resync[ch] && !cfg_en) begin
          state <= seed_a;
        end else if (accept) begin
          state <= (state >> 1) ^ (key ? taps_a : '0);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multi_channel_xor_stream_cipher.sv
`timescale 1ns/1ps
`default_nettype none
// Scoreboard bench: randomized traffic and config shifts checked against a queue-based
// reference model of the config chain and per-channel LFSR keystreams.
module tb_multi_channel_xor_stream_cipher;
  localparam int N = 32;
  localparam int C = 2;
  localparam int L = 2 * N * C;
  localparam logic [N-1:0] TAPS_DEF = 32'h48000000;
  localparam logic [N-1:0] SEED_DEF = 32'h00000055;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cfg_en = 1'b0;
  logic         cfg_i = 1'b0;
  logic         cfg_o;
  logic         cfg_done;
  logic [C-1:0] data_i = '0;
  logic [C-1:0] valid_i = '0;
  logic [C-1:0] resync = '0;
  logic [C-1:0] data_o;
  logic [C-1:0] valid_o;
  logic [C-1:0] locked;

  int checks = 0;
  int errors = 0;

  multi_channel_xor_stream_cipher #(
    .N(N), .C(C), .TAPS_DEFAULT(TAPS_DEF), .SEED_DEFAULT(SEED_DEF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_en(cfg_en), .cfg_i(cfg_i), .cfg_o(cfg_o),
    .cfg_done(cfg_done), .data_i(data_i), .valid_i(valid_i), .resync(resync),
    .data_o(data_o), .valid_o(valid_o), .locked(locked)
  );

  always #5 clk = ~clk;

  // Reference model: chain[0] is the bit next out of cfg_o; new bits join at the back.
  logic         chain[$];
  logic [N-1:0] m_state[C];
  logic [N-1:0] m_taps[C];
  logic [N-1:0] m_seed[C];
  int           m_shifts;
  logic         m_done_pending;
  logic         exp_q[C][$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [N-1:0] chain_field(input int lsb);
    logic [N-1:0] f;
    for (int i = 0; i < N; i++) f[i] = chain[lsb + i];
    return f;
  endfunction

  task automatic model_reset();
    logic [N-1:0] s;
    logic [N-1:0] t;
    s = SEED_DEF;
    t = TAPS_DEF;
    chain.delete();
    for (int ch = 0; ch < C; ch++) begin
      for (int i = 0; i < N; i++) chain.push_back(s[i]);
      for (int i = 0; i < N; i++) chain.push_back(t[i]);
      m_state[ch] = s;
      m_taps[ch]  = t;
      m_seed[ch]  = s;
      exp_q[ch].delete();
    end
    m_shifts       = 0;
    m_done_pending = 1'b0;
  endtask

  // One clock of stimulus; the model is advanced to what the next edge should produce.
  task automatic cycle(input logic en, input logic ci, input logic [C-1:0] v,
                       input logic [C-1:0] d, input logic [C-1:0] rs);
    logic [C-1:0] exp_lock;
    logic         acc;
    @(posedge clk);
    #1;
    check("cfg_done", cfg_done, m_done_pending);
    for (int ch = 0; ch < C; ch++) exp_lock[ch] = (m_state[ch] == 0);
    check("locked", locked, exp_lock);
    cfg_en  = en;
    cfg_i   = ci;
    valid_i = v;
    data_i  = d;
    resync  = rs;
    #1;
    check("cfg_o", cfg_o, en ? chain[0] : 1'b0);
    m_done_pending = 1'b0;
    if (en) begin
      void'(chain.pop_front());
      chain.push_back(ci);
      m_shifts++;
      if (m_shifts == L) begin
        m_shifts       = 0;
        m_done_pending = 1'b1;
        for (int ch = 0; ch < C; ch++) begin
          m_seed[ch]  = chain_field(2 * N * ch);
          m_taps[ch]  = chain_field(2 * N * ch + N);
          m_state[ch] = m_seed[ch];
        end
      end
    end else begin
      m_shifts = 0;
    end
    for (int ch = 0; ch < C; ch++) begin
      acc = !en && v[ch] && (m_state[ch] != 0);
      if (acc) exp_q[ch].push_back(d[ch] ^ m_state[ch][0]);
      if (!en && rs[ch])
        m_state[ch] = m_seed[ch];
      else if (acc)
        m_state[ch] = (m_state[ch] >> 1) ^ (m_state[ch][0] ? m_taps[ch] : '0);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic traffic(input int n);
    for (int i = 0; i < n; i++)
      cycle(1'b0, 1'b0, C'($urandom), C'($urandom), '0);
  endtask

  task automatic shift_word(input logic [L-1:0] w);
    for (int i = 0; i < L; i++) cycle(1'b1, w[i], C'($urandom), C'($urandom), C'($urandom));
  endtask

  // Monitor: every presented output bit is popped and compared against the model's queue.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int ch = 0; ch < C; ch++) begin
        if (valid_o[ch]) begin
          if (exp_q[ch].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid ch%0d at %0t: got valid_o=1, expected 0", ch, $time);
          end else begin
            check($sformatf("data_o[%0d]", ch), data_o[ch], exp_q[ch].pop_front());
          end
        end else begin
          check($sformatf("data_o_idle[%0d]", ch), data_o[ch], 1'b0);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  logic [3:0]   kat;
  logic [L-1:0] word;
  logic         p;
  logic         c;
  logic         prev_c;

  initial begin
    model_reset();
    #12;
    check("rst_data_o", data_o, '0);
    check("rst_valid_o", valid_o, '0);
    check("rst_cfg_done", cfg_done, 1'b0);
    check("rst_locked", locked, '0);
    check("rst_cfg_o", cfg_o, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Known-answer keystream on ch0 with all-ones plaintext.
    kat = 4'b1010;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) cycle(1'b0, 1'b0, 2'b01, 2'b01, '0);
      else       idle(1);
      if (i > 0) begin
        check("kat_valid", valid_o[0], 1'b1);
        check("kat_data", data_o[0], kat[i-1]);
      end
    end

    // Round trip: ch1 decrypts ch0's ciphertext one cycle later.
    cycle(1'b0, 1'b0, '0, '0, 2'b11);
    prev_c = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      p = 1'($urandom);
      c = p ^ m_state[0][0];
      cycle(1'b0, 1'b0, {(i > 0) ? 1'b1 : 1'b0, 1'b1}, {prev_c, p}, '0);
      prev_c = c;
    end
    idle(2);

    // Two back-to-back full shifts: random, then the target configuration.
    word = {$urandom, $urandom, $urandom, $urandom};
    shift_word(word);
    word = {32'h80000057, 32'h00000001, TAPS_DEF, SEED_DEF};
    shift_word(word);
    cycle(1'b0, 1'b0, 2'b10, 2'b00, '0);
    idle(1);
    check("cfg_first_key_ch1", data_o[1], 1'b1);
    traffic(30);

    // Partial shift: nothing commits, keystream resumes.
    for (int i = 0; i < 100; i++) cycle(1'b1, 1'($urandom), 2'b11, C'($urandom), '0);
    traffic(40);

    // Lock: zero seed on ch0, then recover with a nonzero seed.
    word = {32'h80000057, 32'h00000001, TAPS_DEF, 32'h0};
    shift_word(word);
    traffic(10);
    check("locked_ch0", locked[0], 1'b1);
    cycle(1'b0, 1'b0, 2'b11, 2'b11, 2'b01);
    traffic(5);
    word = {32'h80000057, 32'h00000001, TAPS_DEF, ($urandom | 32'h1)};
    shift_word(word);
    traffic(20);
    check("unlocked_ch0", locked[0], 1'b0);

    // Resync overriding a same-cycle step.
    cycle(1'b0, 1'b0, '0, '0, 2'b11);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 2'b01, C'($urandom), '0);
    cycle(1'b0, 1'b0, 2'b01, C'($urandom), 2'b01);
    traffic(5);

    // Random mix of traffic, short config bursts and resyncs.
    for (int i = 0; i < 600; i++)
      cycle(($urandom_range(0, 15) == 0), 1'($urandom), C'($urandom), C'($urandom),
            ($urandom_range(0, 19) == 0) ? C'($urandom) : '0);
    idle(2);

    // Async reset in the middle of a shift.
    for (int i = 0; i < 50; i++) cycle(1'b1, 1'($urandom), 2'b11, C'($urandom), '0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("arst_data_o", data_o, '0);
    check("arst_valid_o", valid_o, '0);
    check("arst_cfg_done", cfg_done, 1'b0);
    check("arst_locked", locked, '0);
    cfg_en  = 1'b0;
    valid_i = '0;
    resync  = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) cycle(1'b0, 1'b0, 2'b01, 2'b01, '0);
      else       idle(1);
      if (i > 0) check("post_rst_kat", data_o[0], kat[i-1]);
    end
    traffic(40);
    shift_word({$urandom, $urandom, $urandom, $urandom});
    traffic(40);
    idle(3);

    for (int ch = 0; ch < C; ch++)
      check($sformatf("drain_q[%0d]", ch), exp_q[ch].size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multi_channel_xor_stream_cipher.md
Name: multi_channel_xor_stream_cipher

Overview:
- Parametrised N-bit Galois-LFSR XOR stream cipher with C independent bit-serial channels.
- Serial config chain loads a shadow register; contents commit atomically to the active LFSRs only after a complete shift.
- Adds per-channel valid handshake, registered outputs, resync to seed, and zero-state lock detection.
- Sits between the bit-serial datapath pins and the config shift interface.

Parameters:
- N, 32, LFSR width (N ≥ 4).
- C, 2, channel count (1..8).
- TAPS_DEFAULT, 'h48000000 (N bits), reset taps for every channel.
- SEED_DEFAULT, 'h00000055 (N bits), reset seed for every channel.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- cfg_en  input  1  config shift enable; also suspends data processing while high.
- cfg_i  input  1  serial config in; enters the shadow MSB.
- cfg_o  output  1  shadow[0] while cfg_en=1, else 0 (combinational).
- cfg_done  output  1  one-cycle pulse after a commit.
- data_i  input  C  plaintext/ciphertext bit per channel.
- valid_i  input  C  per-channel data valid.
- resync  input  C  per-channel reload of the active state from the committed seed.
- data_o  output  C  registered data_i ^ keystream.
- valid_o  output  C  registered accepted-valid.
- locked  output  C  channel active state == 0.

Behaviour:
- Shadow register, L = 2·N·C bits:
  - Layout {ch[C-1].taps, ch[C-1].seed, …, ch0.taps, ch0.seed}.
  - Shifts right while cfg_en=1; cfg_i → MSB.
- Per channel, committed regs: taps_a, seed_a. Active LFSR: state.
- Reset (async, rst_n=0):
  - Shadow and taps_a/seed_a = TAPS_DEFAULT/SEED_DEFAULT per channel.
  - state = SEED_DEFAULT; shift counter = 0.
  - data_o = 0, valid_o = 0, cfg_done = 0, locked = 0 (default seed nonzero).
- Shift counter (width clog2(L+1)):
  - Increments each cfg_en=1 cycle. Clears to 0 on any cycle cfg_en=0.
  - On the edge where it reaches L, for every channel:
    - taps_a/seed_a <= post-shift shadow fields;
    - state <= new seed;
    - counter <= 0.
  - cfg_done = 1 on the following cycle.
  - cfg_en held past L: commits again every L shifts.
  - Partial shift (cfg_en drops before L): shadow keeps the partial contents; taps_a, seed_a and state are unchanged.
- Keystream bit k = state[0].
- Step (Galois, right shift): state <= (state>>1) ^ (state[0] ? taps_a : 0).
- Channel accept: valid_i[ch] & ~cfg_en & ~locked[ch].
  - On accept: data_o[ch] <= data_i[ch] ^ k; valid_o[ch] <= 1; state steps.
  - Not accepted: valid_o[ch] <= 0, data_o[ch] <= 0, state holds.
  - Latency 1 cycle; throughput 1 bit/cycle/channel.
- resync[ch]=1 & cfg_en=0: state <= seed_a.
  - Overrides a same-cycle step.
  - The same-cycle accepted bit still uses the pre-resync k.
- Priority per channel: commit > resync > step > hold.
- resync while cfg_en=1: ignored.
- locked[ch] = (state == 0), registered view of the current state.
  - While locked, the channel accepts nothing; zero keystream is never emitted.
  - Cleared only by a commit or resync that loads a nonzero seed.
  - A committed zero seed sets locked immediately after the commit.
- cfg_en asserted mid-stream: valid_o drops to 0 the next cycle; LFSR states freeze; no data lost beyond bits presented while cfg_en=1 (those are rejected).
- Reset mid-shift: shadow and counter return to defaults; no commit; no cfg_done.
- Channels are fully independent except for the shared config chain and cfg_en.

Test Plan:
- Default keystream: after reset, ch0 valid_i=1, data_i=1 for 4 cycles → data_o = 0,1,0,1. States 0x55 → 0x4800002A → 0x24000015 → 0x5A00000A.
- Round trip: feed ch0 data_o into ch1 (same defaults), one cycle delayed, 1000 random bits → ch1 data_o equals original plaintext.
- Full config (C=2, N=32): shift 128 bits with ch1 seed=0x1, taps=0x80000057 → cfg_done pulses one cycle after the 128th shift. ch1 state = 0x1; first ch1 keystream bit = 1. cfg_o echoes the old shadow bits in order, ch0 seed LSB first.
- Partial config: 100 shifts then cfg_en=0 → no cfg_done; the keystream continues exactly where it stopped.
- Lock: commit ch0 seed=0 → locked[0]=1. valid_i[0]=1 → valid_o[0]=0. Commit a nonzero seed → locked[0]=0 and the channel resumes.
- Resync + async reset: step ch0 5 bits, pulse resync → next output reuses k=1 from seed 0x55. Drop rst_n mid-shift → all outputs 0 immediately; defaults restored.
